keypad_debouncer: RTL
=====================

KEYPAD_DEBOUNCER -- requirements
Module: keypad_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 60000: consecutive matching samples needed to accept a key (~20 ms @ 3 MHz).
REQ-002 Parameter RELEASE_CYCLES, default 30000: cycles without the held key before release; SHALL exceed one full 4-row scan (24000).
REQ-003 clk  input  1  system clock, 3 MHz; the block uses one clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_pressed  input  1  scanner flag: exactly one column low on the active row.
REQ-006 row_idx  input  4  scanner one-hot active row.
REQ-007 col_idx  input  4  scanner one-hot pressed column.
REQ-008 key_valid  output  1  one-cycle pulse telling the scanner to release its row hold and resume scanning.
REQ-009 new_key  output  1  one-cycle pulse marking a newly accepted key.
REQ-010 key_code  output  4  hex code of the last accepted key.
REQ-011 key_held  output  1  high while an accepted key is considered held.

Function
REQ-012 The sample SHALL be valid only when key_pressed=1 and row_idx and col_idx are each exactly one-hot; any other input is treated as no key.
REQ-013 Decode SHALL be: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D (col0..col3).
REQ-014 The FSM SHALL have states IDLE, DEBOUNCE and HELD; key_held=1 exactly when the state is HELD.
REQ-015 IDLE: on a valid sample, latch cand_row/cand_col, clear the counter and go to DEBOUNCE; no key_valid is issued.
REQ-016 DEBOUNCE, sample matches the candidate: the counter increments.
REQ-017 DEBOUNCE accept: when the counter equals DEBOUNCE_CYCLES-1 and the sample matches, the next edge SHALL go to HELD with key_valid=1, new_key=1 and key_code loaded, all in the same cycle.
REQ-018 DEBOUNCE abort: on an invalid or mismatching sample, the next edge SHALL go to IDLE and pulse key_valid for one cycle, with no new_key.
REQ-019 HELD: a valid sample equal to the held key clears the release counter; any other cycle increments it.
REQ-020 HELD release: when the release counter equals RELEASE_CYCLES-1 with no match, the next edge SHALL go to IDLE.
REQ-021 HELD: every valid sample (held key or a different key) SHALL cause a key_valid pulse on the next edge, unless key_valid is already high; key_valid is never high two consecutive cycles.
REQ-022 A different key while in HELD SHALL NOT change key_code or raise new_key.
REQ-023 Counters SHALL be 32-bit unsigned and SHALL saturate, never wrap.
REQ-024 All outputs SHALL be registered; latency from the accepting sample to new_key is 1 cycle.

Reset
REQ-025 While rst=1 at a clk edge: state=IDLE, counters=0, cand_row/cand_col=0, key_valid=0, new_key=0, key_code=0, key_held=0.
REQ-026 Reset in any state, including mid-DEBOUNCE or HELD, SHALL produce no pulse on the following cycle.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enum, the 4-bit key-code constants, and the scanner row-hold/release convention.
REQ-028 The one-hot to code decode (code + valid) SHALL be the sub-module keypad_decoder, purely combinational; keypad_debouncer instantiates it once.

Verification (DEBOUNCE_CYCLES=8, RELEASE_CYCLES=16)
REQ-029 rst=1 for 3 cycles, then 0, with no key -> all outputs 0 and key_held=0 for 50 cycles.
REQ-030 Steady row_idx=0010, col_idx=0100, key_pressed=1 -> exactly 9 cycles after the first sample: new_key=1, key_valid=1 for one cycle, key_code=6, key_held=1.
REQ-031 Same press for 4 cycles, then key_pressed=0 -> one key_valid pulse, no new_key, state IDLE.
REQ-032 In HELD (key 6), key_pressed=0 for 16 cycles -> key_held=0 on the next cycle; a matching sample at cycle 10 restarts the count.
REQ-033 In HELD (key 6), sample row_idx=1000, col_idx=0001 -> key_valid pulse next cycle, new_key=0, key_code stays 6.
REQ-034 rst=1 at DEBOUNCE count 5 -> IDLE, no key_valid or new_key; row_idx=0011 afterwards is ignored.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key codes and scanner handshake constants for the keypad debouncer slice.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kd_state_t;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // Scanner freezes on the row showing a press and resumes scanning when key_valid is high.
  localparam logic        SCAN_RESUME_LEVEL = 1'b1;
  localparam int unsigned SCAN_ROW_CYCLES   = 6000;
  localparam int unsigned SCAN_FULL_CYCLES  = 4 * SCAN_ROW_CYCLES;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Combinational one-hot row/column to hex key-code decode with sample validity.
module keypad_decoder
  import keypad_pkg::*;
(
  input  logic       key_pressed,
  input  logic [3:0] row_idx,
  input  logic [3:0] col_idx,
  output logic [3:0] code,
  output logic       valid
);

  always_comb begin
    valid = key_pressed && is_onehot4(row_idx) && is_onehot4(col_idx);
    code  = KEY_0;
    case ({onehot_idx(row_idx), onehot_idx(col_idx)})
      4'h0: code = KEY_1;
      4'h1: code = KEY_2;
      4'h2: code = KEY_3;
      4'h3: code = KEY_A;
      4'h4: code = KEY_4;
      4'h5: code = KEY_5;
      4'h6: code = KEY_6;
      4'h7: code = KEY_B;
      4'h8: code = KEY_7;
      4'h9: code = KEY_8;
      4'hA: code = KEY_9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_E;
      4'hD: code = KEY_0;
      4'hE: code = KEY_F;
      4'hF: code = KEY_D;
    endcase
  end

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces scanner samples into accepted keys, tracks hold/release and paces the scanner.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 60000,
  parameter int unsigned RELEASE_CYCLES  = 30000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pressed,
  input  logic [3:0] row_idx,
  input  logic [3:0] col_idx,
  output logic       key_valid,
  output logic       new_key,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] REL_LAST = 32'(RELEASE_CYCLES - 1);

  kd_state_t   state;
  logic [31:0] deb_cnt;
  logic [31:0] rel_cnt;
  logic [3:0]  cand_row;
  logic [3:0]  cand_col;
  logic [3:0]  dec_code;
  logic        sample_ok;
  logic        match;

  keypad_decoder u_decoder (
    .key_pressed (key_pressed),
    .row_idx     (row_idx),
    .col_idx     (col_idx),
    .code        (dec_code),
    .valid       (sample_ok)
  );

  assign match = sample_ok && (row_idx == cand_row) && (col_idx == cand_col);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
      key_valid <= 1'b0;
      new_key   <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      new_key   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample_ok) begin
            cand_row <= row_idx;
            cand_col <= col_idx;
            deb_cnt  <= '0;
            state    <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (match) begin
            if (deb_cnt == DEB_LAST) begin
              state     <= ST_HELD;
              key_held  <= 1'b1;
              key_valid <= 1'b1;
              new_key   <= 1'b1;
              key_code  <= dec_code;
              rel_cnt   <= '0;
            end else begin
              deb_cnt <= sat_inc(deb_cnt);
            end
          end else begin
            state     <= ST_IDLE;
            key_valid <= ~key_valid;
          end
        end
        ST_HELD: begin
          // Any valid sample re-arms the scanner, but never on back-to-back cycles.
          if (sample_ok)
            key_valid <= ~key_valid;
          if (match) begin
            rel_cnt <= '0;
          end else if (rel_cnt == REL_LAST) begin
            state    <= ST_IDLE;
            key_held <= 1'b0;
          end else begin
            rel_cnt <= sat_inc(rel_cnt);
          end
        end
        default: begin
          state    <= ST_IDLE;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule
